// File: rtl/alu_pipe_if.sv
// Operand/result bus of the pipelined ALU: input handshake, output handshake,
// result flags, error status and transaction counter.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [3:0]       Alu_Cntrl;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] OUT;
    logic             Zero;
    logic             oVerflow;
    logic             Carry;
    logic             Negative;
    logic             Illegal;
    logic             err_sticky;
    logic             err_clr;
    logic [15:0]      op_count;

    modport master (
        output in_valid, A_in, B_in, Alu_Cntrl, Cin, out_ready, err_clr,
        input  in_ready, out_valid, OUT, Zero, oVerflow, Carry, Negative,
               Illegal, err_sticky, op_count
    );

    modport slave (
        input  in_valid, A_in, B_in, Alu_Cntrl, Cin, out_ready, err_clr,
        output in_ready, out_valid, OUT, Zero, oVerflow, Carry, Negative,
               Illegal, err_sticky, op_count
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: compute in the first stage, pure delay afterwards, with a
// global stall (advance) driven by the output handshake.
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_EQ   = 4'd0,
        OP_LT   = 4'd1,
        OP_LTU  = 4'd2,
        OP_GT   = 4'd3,
        OP_GTU  = 4'd4,
        OP_ADD  = 4'd5,
        OP_ADDU = 4'd6,
        OP_SUB  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_OR   = 4'd11,
        OP_XOR  = 4'd12,
        OP_AND  = 4'd13
    } op_e;

    typedef struct packed {
        logic             ill;
        logic             z;
        logic             v;
        logic             c;
        logic             n;
        logic [WIDTH-1:0] res;
    } result_t;

    result_t          calc_d;
    result_t          data_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] bNeg_d;
    logic [SW-1:0]    shamt_d;
    logic             advance;
    logic             inXfer;
    logic             outXfer;
    logic             err_q;
    logic [15:0]      cnt_q;

    assign shamt_d = bus.B_in[SW-1:0];
    assign bNeg_d  = ~bus.B_in + WIDTH'(1);

    always_comb begin
        calc_d = '0;
        sum_d  = '0;
        case (op_e'(bus.Alu_Cntrl))
            OP_EQ:   calc_d.z = (bus.A_in == bus.B_in);
            OP_LT:   calc_d.z = ($signed(bus.A_in) < $signed(bus.B_in));
            OP_LTU:  calc_d.z = (bus.A_in < bus.B_in);
            OP_GT:   calc_d.z = ($signed(bus.A_in) > $signed(bus.B_in));
            OP_GTU:  calc_d.z = (bus.A_in > bus.B_in);
            OP_ADD, OP_ADDU: begin
                sum_d      = {1'b0, bus.A_in} + {1'b0, bus.B_in} + {{WIDTH{1'b0}}, bus.Cin};
                calc_d.res = sum_d[MSB:0];
                calc_d.c   = sum_d[WIDTH];
                calc_d.v   = (bus.A_in[MSB] == bus.B_in[MSB]) & (bus.A_in[MSB] != sum_d[MSB]);
            end
            OP_SUB: begin
                sum_d      = {1'b0, bus.A_in} + {1'b0, bNeg_d} + {{WIDTH{1'b0}}, bus.Cin};
                calc_d.res = sum_d[MSB:0];
                calc_d.c   = sum_d[WIDTH];
                calc_d.v   = (bus.A_in[MSB] != bus.B_in[MSB]) & (bus.A_in[MSB] != sum_d[MSB]);
            end
            OP_SLL:  calc_d.res = bus.A_in << shamt_d;
            OP_SRL:  calc_d.res = bus.A_in >> shamt_d;
            OP_SRA:  calc_d.res = $signed(bus.A_in) >>> shamt_d;
            OP_OR:   calc_d.res = bus.A_in | bus.B_in;
            OP_XOR:  calc_d.res = bus.A_in ^ bus.B_in;
            OP_AND:  calc_d.res = bus.A_in & bus.B_in;
            default: calc_d.ill = 1'b1;
        endcase
        calc_d.n = calc_d.ill ? 1'b0 : calc_d.res[MSB];
    end

    // Every stage moves together; a bubble is simply a stage with valid low.
    assign advance = ~valid_q[STAGES-1] | bus.out_ready;
    assign inXfer  = bus.in_valid & advance;
    assign outXfer = valid_q[STAGES-1] & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= bus.in_valid;
            data_q[0]  <= calc_d;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // A new illegal delivery takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (outXfer && data_q[STAGES-1].ill) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            if (inXfer && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.in_ready   = advance;
    assign bus.out_valid  = valid_q[STAGES-1];
    assign bus.OUT        = data_q[STAGES-1].res;
    assign bus.Zero       = data_q[STAGES-1].z;
    assign bus.oVerflow   = data_q[STAGES-1].v;
    assign bus.Carry      = data_q[STAGES-1].c;
    assign bus.Negative   = data_q[STAGES-1].n;
    assign bus.Illegal    = data_q[STAGES-1].ill;
    assign bus.err_sticky = err_q;
    assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus a randomized run
// scored against an arithmetic reference model and an in-order queue.
module tb_alu_pipe;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    typedef struct packed {
        logic        ill;
        logic        z;
        logic        v;
        logic        c;
        logic        n;
        logic [31:0] res;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } entry_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    entry_t sb[$];
    res_t   outLog[$];
    int     cyc;
    int     passCnt;
    int     totalCnt;
    int     failCnt;
    int     opModel;
    logic   errModel;
    logic   prevStall;
    res_t   prevObs;
    int     lastLat;
    logic   lastOv;
    logic   lastInReady;

    function automatic res_t refModel(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin);
        res_t r;
        longint unsigned s;
        longint unsigned negB;
        longint ss;
        int sh;
        r  = '0;
        sh = int'(b[4:0]);
        case (op)
            4'd0: r.z = (a == b);
            4'd1: r.z = ($signed(a) < $signed(b));
            4'd2: r.z = (a < b);
            4'd3: r.z = ($signed(a) > $signed(b));
            4'd4: r.z = (a > b);
            4'd5, 4'd6: begin
                s     = {32'h0, a} + {32'h0, b} + {63'h0, cin};
                r.res = s[31:0];
                r.c   = s[32];
                ss    = longint'($signed(a)) + longint'($signed(b)) + longint'({63'h0, cin});
                r.v   = (ss > MAXS) || (ss < MINS);
            end
            4'd7: begin
                negB  = (64'h1_0000_0000 - {32'h0, b}) & 64'hFFFF_FFFF;
                s     = {32'h0, a} + negB + {63'h0, cin};
                r.res = s[31:0];
                r.c   = s[32];
                r.v   = (a[31] != b[31]) && (a[31] != r.res[31]);
            end
            4'd8:  r.res = a << sh;
            4'd9:  r.res = a >> sh;
            4'd10: r.res = $signed(a) >>> sh;
            4'd11: r.res = a | b;
            4'd12: r.res = a ^ b;
            4'd13: r.res = a & b;
            default: r.ill = 1'b1;
        endcase
        if (!r.ill) r.n = r.res[31];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle at the falling edge, scores what the DUT shows, then
    // advances to the next falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin, input logic ordy,
                                 input logic clr);
        res_t   obs;
        res_t   exp;
        logic   ov;
        logic   ir;
        entry_t e;
        bus.in_valid  = v;
        bus.Alu_Cntrl = op;
        bus.A_in      = a;
        bus.B_in      = b;
        bus.Cin       = cin;
        bus.out_ready = ordy;
        bus.err_clr   = clr;
        #1;
        ov  = bus.out_valid;
        ir  = bus.in_ready;
        obs = {bus.Illegal, bus.Zero, bus.oVerflow, bus.Carry, bus.Negative, bus.OUT};
        lastOv      = ov;
        lastInReady = ir;
        checkOutput("in_ready", {63'h0, ir}, {63'h0, (!ov || ordy)});
        checkOutput("op_count", {48'h0, bus.op_count}, 64'(opModel));
        checkOutput("err_sticky", {63'h0, bus.err_sticky}, {63'h0, errModel});
        if (prevStall) begin
            checkOutput("stall_valid", {63'h0, ov}, 64'h1);
            checkOutput("stall_hold", 64'(obs), 64'(prevObs));
        end
        if (sb.size() == 0) checkOutput("spurious_valid", {63'h0, ov}, 64'h0);
        exp = '0;
        if (ov && ordy && sb.size() > 0) begin
            e   = sb.pop_front();
            exp = e.r;
            checkOutput("result", 64'(obs), 64'(e.r));
            lastLat = cyc - e.cyc;
            outLog.push_back(obs);
        end
        errModel = (ov && ordy && exp.ill) ? 1'b1 : (clr ? 1'b0 : errModel);
        if (v && ir) begin
            e.r   = refModel(op, a, b, cin);
            e.cyc = cyc;
            sb.push_back(e);
            if (opModel < 65535) opModel++;
        end
        prevStall = ov && !ordy;
        prevObs   = obs;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        checkOutput("rst_op_count", {48'h0, bus.op_count}, 64'h0);
        checkOutput("rst_err", {63'h0, bus.err_sticky}, 64'h0);
        checkOutput("rst_outputs",
                    {27'h0, bus.Illegal, bus.Zero, bus.oVerflow, bus.Carry, bus.Negative, bus.OUT},
                    64'h0);
        sb.delete();
        outLog.delete();
        opModel   = 0;
        errModel  = 1'b0;
        prevStall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    endtask

    initial begin
        passCnt = 0; totalCnt = 0; failCnt = 0; cyc = 0; lastLat = 0;
        opModel = 0; errModel = 1'b0; prevStall = 1'b0; prevObs = '0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.Alu_Cntrl = '0;
        bus.Cin = 1'b0; bus.out_ready = 1'b1; bus.err_clr = 1'b0;
        @(negedge clk);
        doReset();

        // Carry out of an all-ones add, with exact latency.
        applyStimulus(1, 4'd5, 32'hFFFF_FFFF, 32'h1, 0, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req036_not_early", {63'h0, lastOv}, 64'h0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req036_valid", {63'h0, lastOv}, 64'h1);
        checkOutput("req036_out", 64'(outLog[0]), {27'h0, 5'b00010, 32'h0000_0000});
        checkOutput("req036_latency", 64'(lastLat), 64'(STAGES));

        outLog.delete();
        applyStimulus(1, 4'd5,  32'h7FFF_FFFF, 32'h1, 0, 1, 0);
        applyStimulus(1, 4'd7,  32'h5,         32'h7, 0, 1, 0);
        applyStimulus(1, 4'd10, 32'h8000_0000, 32'h4, 0, 1, 0);
        applyStimulus(1, 4'd1,  32'hFFFF_FFFF, 32'h1, 0, 1, 0);
        applyStimulus(1, 4'd2,  32'hFFFF_FFFF, 32'h1, 0, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("dir_count", 64'(outLog.size()), 64'd5);
        checkOutput("add_ovf",  64'(outLog[0]), {27'h0, 5'b00101, 32'h8000_0000});
        checkOutput("sub_neg",  64'(outLog[1]), {27'h0, 5'b00001, 32'hFFFF_FFFE});
        checkOutput("sra_fill", 64'(outLog[2]), {27'h0, 5'b00001, 32'hF800_0000});
        checkOutput("lt_signed", 64'(outLog[3]), {27'h0, 5'b01000, 32'h0});
        checkOutput("ltu_unsigned", 64'(outLog[4]), {27'h0, 5'b00000, 32'h0});

        // Back-pressure: three ops, consumer stalls for three cycles.
        doReset();
        applyStimulus(1, 4'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0);
        applyStimulus(1, 4'd11, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0);
        applyStimulus(1, 4'd12, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 0, 0);
        checkOutput("req039_in_ready", {63'h0, lastInReady}, 64'h0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req039_results", 64'(outLog.size()), 64'd3);
        checkOutput("req039_and", 64'(outLog[0]), {27'h0, 5'b00000, 32'h00F0_00F0});
        checkOutput("req039_or",  64'(outLog[1]), {27'h0, 5'b00001, 32'hFFF0_FFF0});
        checkOutput("req039_xor", 64'(outLog[2]), {27'h0, 5'b00001, 32'hFF00_FF00});
        checkOutput("req039_op_count", {48'h0, bus.op_count}, 64'd3);

        // Illegal opcode sets the sticky error until cleared.
        doReset();
        applyStimulus(1, 4'd14, 32'h1234, 32'h5, 1, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req040_out", 64'(outLog[0]), {27'h0, 5'b10000, 32'h0});
        checkOutput("req040_err_set", {63'h0, bus.err_sticky}, 64'h1);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req040_err_hold", {63'h0, bus.err_sticky}, 64'h1);
        applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 1);
        checkOutput("req040_err_clr", {63'h0, bus.err_sticky}, 64'h0);

        // Reset with two transactions in flight.
        doReset();
        applyStimulus(1, 4'd5, 32'h10, 32'h20, 0, 1, 0);
        applyStimulus(1, 4'd7, 32'h30, 32'h05, 0, 1, 0);
        checkOutput("req041_in_flight", {63'h0, bus.out_valid}, 64'h1);
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        checkOutput("req041_no_result", 64'(outLog.size()), 64'd0);

        // Randomized traffic with random back-pressure and clears.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            applyStimulus(0, 4'd0, 32'h0, 32'h0, 0, 1, 0);
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, >= 8.
REQ-002 Parameter STAGES, default 2: pipeline depth in cycles, 1..4.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
REQ-005 in_valid  in  1  operand set present.
REQ-006 in_ready  out  1  block accepts operands this cycle.
REQ-007 A_in  in  WIDTH  operand A.
REQ-008 B_in  in  WIDTH  operand B; shift amount is B_in[$clog2(WIDTH)-1:0].
REQ-009 Alu_Cntrl  in  4  opcode.
REQ-010 Cin  in  1  carry-in for ADD/ADDU/SUB.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 OUT  out  WIDTH  result.
REQ-014 Zero, oVerflow, Carry, Negative  out  1 each  flags.
REQ-015 Illegal  out  1  result came from undefined opcode.
REQ-016 err_sticky  out  1  set by any illegal result delivered.
REQ-017 err_clr  in  1  synchronous clear of err_sticky.
REQ-018 op_count  out  16  accepted-transaction counter.

Function
REQ-019 Opcodes: 0 EQ, 1 LT signed, 2 LTU, 3 GT signed, 4 GTU, 5 ADD, 6 ADDU, 7 SUB, 8 SLL, 9 SRL, 10 SRA, 11 OR, 12 XOR, 13 AND; 14,15 illegal.
REQ-020 Compares (0-4): Zero = comparison result, OUT=0, Carry=0, oVerflow=0.
REQ-021 ADD/ADDU: {C,OUT} = {0,A}+{0,B}+Cin; oVerflow = (A[MSB]==B[MSB]) & (A[MSB]!=OUT[MSB]); Zero=0.
REQ-022 SUB: {C,OUT} = {0,A}+{0,(~B+1) truncated to WIDTH}+Cin; oVerflow = (A[MSB]!=B[MSB]) & (A[MSB]!=OUT[MSB]); Zero=0.
REQ-023 Shifts/logic (8-13): standard result, SRA sign-fills; Carry=oVerflow=Zero=0.
REQ-024 Negative = OUT[MSB] for every legal opcode.
REQ-025 Illegal opcode: OUT=0, all four flags 0, Illegal=1; Illegal=0 for legal opcodes.
REQ-026 Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-027 advance = ~out_valid | out_ready; in_ready = advance; all STAGES registers shift only when advance=1.
REQ-028 Latency: result of a transfer appears on out_valid exactly STAGES cycles later absent stalls; throughput 1/cycle.
REQ-029 Stall: while out_valid=1 & out_ready=0, OUT, flags, Illegal, out_valid hold stable; no inputs accepted.
REQ-030 Bubbles travel with data (valid bit per stage); in_valid=0 inserts a bubble.
REQ-031 op_count increments by 1 per input transfer, saturates at 16'hFFFF.
REQ-032 err_sticky sets on output transfer with Illegal=1; err_clr=1 clears it; simultaneous set and clear -> set wins.
REQ-033 Combinational compute occurs in stage 1; later stages are pure delay.

Reset
REQ-034 reset=0: all stage valids, out_valid, OUT, flags, Illegal, err_sticky, op_count = 0; in_ready = 1 after reset release.
REQ-035 Reset mid-operation discards all in-flight transactions; no partial result emitted after release.

Verification (WIDTH=32, STAGES=2, out_ready=1 unless stated)
REQ-036 ADD A=FFFFFFFF B=00000001 Cin=0 -> 2 cycles later OUT=00000000, C=1, V=0, N=0, Z=0.
REQ-037 ADD A=7FFFFFFF B=00000001 Cin=0 -> OUT=80000000, V=1, N=1, C=0; SUB A=5 B=7 Cin=0 -> OUT=FFFFFFFE, C=0, V=0, N=1.
REQ-038 SRA A=80000000 B=4 -> OUT=F8000000, N=1; LT A=FFFFFFFF B=1 -> Z=1; LTU same operands -> Z=0.
REQ-039 Three back-to-back ops, out_ready=0 for 3 cycles after first out_valid -> in_ready=0, outputs held, then three results in order, op_count=3.
REQ-040 Opcode 14 -> OUT=0, Illegal=1, err_sticky=1 after transfer, remains 1 until err_clr pulse, then 0.
REQ-041 reset=0 asserted with 2 ops in flight -> out_valid=0 immediately, op_count=0, no result after release.
